// File: rtl/uop_pkg.sv
// Shared uop types and queue sizing for the decode-to-rename path.
// Helper functions cover lane popcount and the contiguous-mask rule for enqueue groups.
package uop_pkg;

    localparam int INSTR_Q_WIDTH = 4;
    localparam int UOP_Q_DEPTH   = 16;
    localparam int UOP_Q_CNT_W   = $clog2(UOP_Q_DEPTH + 1);
    localparam int UOP_Q_PTR_W   = $clog2(UOP_Q_DEPTH);
    localparam int UOP_LANE_W    = $clog2(INSTR_Q_WIDTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } uop_insn;

    function automatic logic [UOP_LANE_W-1:0] lane_popcount(input logic [INSTR_Q_WIDTH-1:0] mask);
        logic [UOP_LANE_W-1:0] n;
        n = '0;
        for (int i = 0; i < INSTR_Q_WIDTH; i++) begin
            n = n + UOP_LANE_W'(mask[i]);
        end
        return n;
    endfunction

    // A legal mask is a run of ones starting at lane 0, so adding one clears every set bit.
    function automatic logic lane_mask_contiguous(input logic [INSTR_Q_WIDTH-1:0] mask);
        logic [INSTR_Q_WIDTH-1:0] inc;
        inc = mask + 1'b1;
        return (mask & inc) == '0;
    endfunction

endpackage

// File: rtl/uop_instr_queue_if.sv
// Decoder/RAT-facing handshake bundle of the uop instruction queue.
// slave is the queue side; master is the decoder plus RAT side.
interface uop_instr_queue_if;
    import uop_pkg::*;

    logic [INSTR_Q_WIDTH-1:0]    enq_valid_in;
    uop_insn [INSTR_Q_WIDTH-1:0] enq_uops_in;
    logic                        enq_ready_out;
    logic                        q_valid_out;
    logic [INSTR_Q_WIDTH-1:0]    q_slot_valid_out;
    uop_insn [INSTR_Q_WIDTH-1:0] instr_out;
    logic                        q_increment_ready_in;
    logic [UOP_Q_CNT_W-1:0]      count_out;

    modport slave (
        input  enq_valid_in,
        input  enq_uops_in,
        input  q_increment_ready_in,
        output enq_ready_out,
        output q_valid_out,
        output q_slot_valid_out,
        output instr_out,
        output count_out
    );

    modport master (
        output enq_valid_in,
        output enq_uops_in,
        output q_increment_ready_in,
        input  enq_ready_out,
        input  q_valid_out,
        input  q_slot_valid_out,
        input  instr_out,
        input  count_out
    );

endinterface

// File: rtl/uop_q_perf_counters.sv
// Saturating occupancy/flush statistics for the uop queue (built only with UOP_Q_PERF_CNT_EN).
// Flush does not clear these; only reset does.
module uop_q_perf_counters
    import uop_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   rst_N_in,
    input  logic                   flush_in,
    input  logic [UOP_Q_CNT_W-1:0] count_in,
    output logic [31:0]            perf_full_cycles_out,
    output logic [31:0]            perf_empty_cycles_out,
    output logic [31:0]            perf_flush_cnt_out
);

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            perf_full_cycles_out  <= '0;
            perf_empty_cycles_out <= '0;
            perf_flush_cnt_out    <= '0;
        end else begin
            if (count_in == UOP_Q_CNT_W'(UOP_Q_DEPTH) && perf_full_cycles_out != '1)
                perf_full_cycles_out <= perf_full_cycles_out + 32'd1;
            if (count_in == '0 && perf_empty_cycles_out != '1)
                perf_empty_cycles_out <= perf_empty_cycles_out + 32'd1;
            if (flush_in && perf_flush_cnt_out != '1)
                perf_flush_cnt_out <= perf_flush_cnt_out + 32'd1;
        end
    end

endmodule

// File: rtl/uop_instr_queue.sv
// Decoupling FIFO between decoder and rename: enqueues up to INSTR_Q_WIDTH uops per cycle and
// presents head groups to the RAT. Optional perf counters under `UOP_Q_PERF_CNT_EN.
module uop_instr_queue
    import uop_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_N_in,
    input  logic               flush_in,
    uop_instr_queue_if.slave   q_if
`ifdef UOP_Q_PERF_CNT_EN
    ,
    output logic [31:0]        perf_full_cycles_out,
    output logic [31:0]        perf_empty_cycles_out,
    output logic [31:0]        perf_flush_cnt_out
`endif
);

    localparam int Q     = INSTR_Q_WIDTH;
    localparam int DEPTH = UOP_Q_DEPTH;

    uop_insn                mem [DEPTH];
    logic [UOP_Q_PTR_W-1:0] head;
    logic [UOP_Q_PTR_W-1:0] tail;
    logic [UOP_Q_CNT_W-1:0] count;

    logic                   enq_ready;
    logic                   q_valid;
    logic [UOP_LANE_W-1:0]  avail;
    logic [UOP_LANE_W-1:0]  n_enq;
    logic                   enq_fire;
    logic                   deq_fire;
    logic [UOP_Q_CNT_W-1:0] enq_amt;
    logic [UOP_Q_CNT_W-1:0] deq_amt;
    logic [Q-1:0]           slot_valid;

    // Partial groups drain only while the decoder is idle, so full groups are preferred.
    always_comb begin
        enq_ready  = (UOP_Q_CNT_W'(DEPTH) - count) >= UOP_Q_CNT_W'(Q);
        q_valid    = (count >= UOP_Q_CNT_W'(Q)) || ((count != '0) && (q_if.enq_valid_in == '0));
        avail      = (count >= UOP_Q_CNT_W'(Q)) ? UOP_LANE_W'(Q) : count[UOP_LANE_W-1:0];
        n_enq      = lane_popcount(q_if.enq_valid_in);
        enq_fire   = enq_ready && (|q_if.enq_valid_in);
        deq_fire   = q_valid && q_if.q_increment_ready_in;
        enq_amt    = enq_fire ? UOP_Q_CNT_W'(n_enq) : '0;
        deq_amt    = deq_fire ? UOP_Q_CNT_W'(avail) : '0;
        slot_valid = '0;
        for (int i = 0; i < Q; i++) begin
            slot_valid[i] = q_valid && (UOP_LANE_W'(i) < avail);
        end
    end

    // Unused lanes are forced to zero so reset shows a clean bus over uninitialised storage.
    always_comb begin
        q_if.enq_ready_out    = enq_ready;
        q_if.q_valid_out      = q_valid;
        q_if.q_slot_valid_out = slot_valid;
        q_if.count_out        = count;
        for (int i = 0; i < Q; i++) begin
            q_if.instr_out[i] = slot_valid[i] ? mem[head + UOP_Q_PTR_W'(i)] : '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (enq_fire && !flush_in) begin
            for (int i = 0; i < Q; i++) begin
                if (q_if.enq_valid_in[i])
                    mem[tail + UOP_Q_PTR_W'(i)] <= q_if.enq_uops_in[i];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + UOP_Q_PTR_W'(enq_amt);
            head  <= head + UOP_Q_PTR_W'(deq_amt);
            count <= count + enq_amt - deq_amt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_N_in && (|q_if.enq_valid_in))
            assert (lane_mask_contiguous(q_if.enq_valid_in));
    end

`ifdef UOP_Q_PERF_CNT_EN
    uop_q_perf_counters u_perf (
        .clk_in                (clk_in),
        .rst_N_in              (rst_N_in),
        .flush_in              (flush_in),
        .count_in              (count),
        .perf_full_cycles_out  (perf_full_cycles_out),
        .perf_empty_cycles_out (perf_empty_cycles_out),
        .perf_flush_cnt_out    (perf_flush_cnt_out)
    );
`endif

endmodule
